// File: rtl/tl_source_shrinker_pkg.sv
// Shared TileLink opcode encodings and payload layout helpers for the source shrinker.
// Payloads are flat vectors, MSB first: opcode, param, size, ..., corrupt, source.
`default_nettype none

package tl_source_shrinker_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    ArithmeticData = 3'd2,
    LogicalData    = 3'd3,
    Get            = 3'd4,
    Intent         = 3'd5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1,
    HintAck       = 3'd2,
    Grant         = 3'd4,
    GrantData     = 3'd5,
    ReleaseAck    = 3'd6
  } tl_d_op_e;

  function automatic int size_width(input int max_size);
    return $clog2(max_size + 1);
  endfunction

  // opcode, param(3), size, address, mask, data, corrupt
  function automatic int a_fields_width(input int aw, input int dw, input int szw);
    return 3 + 3 + szw + aw + dw / 8 + dw + 1;
  endfunction

  // opcode, param(2), size, address, mask, data, corrupt
  function automatic int b_fields_width(input int aw, input int dw, input int szw);
    return 3 + 2 + szw + aw + dw / 8 + dw + 1;
  endfunction

  // opcode, param(3), size, address, data, corrupt
  function automatic int c_fields_width(input int aw, input int dw, input int szw);
    return 3 + 3 + szw + aw + dw + 1;
  endfunction

  // opcode, param(2), size, sink, denied, data, corrupt
  function automatic int d_fields_width(input int skw, input int dw, input int szw);
    return 3 + 2 + szw + skw + 1 + dw + 1;
  endfunction

  function automatic logic a_has_data(input logic [2:0] op);
    return op < 3'd4;
  endfunction

  function automatic logic d_has_data(input logic [2:0] op);
    return (op == AccessAckData) || (op == GrantData);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tl_burst_tracker.sv
// Beat counters for the A (request) and D (grant) channels of one TileLink link.
// A message's beat count comes from its opcode and size on the first beat.
`default_nettype none

module tl_burst_tracker
  import tl_source_shrinker_pkg::*;
#(
  parameter int DataWidth = 64,
  parameter int MaxSize   = 6,
  parameter int SizeWidth = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 a_fire_i,
  input  logic [2:0]           a_opcode_i,
  input  logic [SizeWidth-1:0] a_size_i,
  input  logic                 d_fire_i,
  input  logic [2:0]           d_opcode_i,
  input  logic [SizeWidth-1:0] d_size_i,
  output logic                 req_first_o,
  output logic                 req_last_o,
  output logic                 gnt_last_o
);

  localparam int BeatShift = $clog2(DataWidth / 8);
  localparam int CntWidth  = MaxSize + 1;

  function automatic logic [CntWidth-1:0] beats_m1(input logic has_data,
                                                   input logic [SizeWidth-1:0] size);
    logic [CntWidth-1:0] bytes_m1;
    bytes_m1 = (CntWidth'(1) << size) - CntWidth'(1);
    return has_data ? (bytes_m1 >> BeatShift) : '0;
  endfunction

  // Counters hold the beats still to come after the current one; zero means idle.
  logic [CntWidth-1:0] req_cnt_q, gnt_cnt_q;
  logic [CntWidth-1:0] req_len, gnt_len;
  logic                gnt_first;

  assign req_len     = beats_m1(a_has_data(a_opcode_i), a_size_i);
  assign gnt_len     = beats_m1(d_has_data(d_opcode_i), d_size_i);
  assign req_first_o = (req_cnt_q == '0);
  assign gnt_first   = (gnt_cnt_q == '0);
  assign req_last_o  = req_first_o ? (req_len == '0) : (req_cnt_q == CntWidth'(1));
  assign gnt_last_o  = gnt_first ? (gnt_len == '0) : (gnt_cnt_q == CntWidth'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_cnt_q <= '0;
      gnt_cnt_q <= '0;
    end else begin
      if (a_fire_i) req_cnt_q <= req_first_o ? req_len : req_cnt_q - CntWidth'(1);
      if (d_fire_i) gnt_cnt_q <= gnt_first ? gnt_len : gnt_cnt_q - CntWidth'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tl_source_shrinker.sv
// Remaps wide host A-channel source IDs onto a small pool of device IDs and
// restores the original source on D responses. Back-pressures A when the pool is full.
`default_nettype none

module tl_source_shrinker
  import tl_source_shrinker_pkg::*;
#(
  parameter int AddrWidth         = 56,
  parameter int DataWidth         = 64,
  parameter int SinkWidth         = 1,
  parameter int HostSourceWidth   = 4,
  parameter int DeviceSourceWidth = 1,
  parameter int MaxSize           = 6,
  localparam int SizeWidth        = size_width(MaxSize),
  localparam int AFields          = a_fields_width(AddrWidth, DataWidth, SizeWidth),
  localparam int BFields          = b_fields_width(AddrWidth, DataWidth, SizeWidth),
  localparam int CFields          = c_fields_width(AddrWidth, DataWidth, SizeWidth),
  localparam int DFields          = d_fields_width(SinkWidth, DataWidth, SizeWidth)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,

  input  logic                                 host_a_valid,
  output logic                                 host_a_ready,
  input  logic [AFields+HostSourceWidth-1:0]   host_a,
  output logic                                 host_b_valid,
  input  logic                                 host_b_ready,
  output logic [BFields+HostSourceWidth-1:0]   host_b,
  input  logic                                 host_c_valid,
  output logic                                 host_c_ready,
  input  logic [CFields+HostSourceWidth-1:0]   host_c,
  output logic                                 host_d_valid,
  input  logic                                 host_d_ready,
  output logic [DFields+HostSourceWidth-1:0]   host_d,
  input  logic                                 host_e_valid,
  output logic                                 host_e_ready,
  input  logic [SinkWidth-1:0]                 host_e,

  output logic                                 device_a_valid,
  input  logic                                 device_a_ready,
  output logic [AFields+DeviceSourceWidth-1:0] device_a,
  input  logic                                 device_b_valid,
  output logic                                 device_b_ready,
  input  logic [BFields+DeviceSourceWidth-1:0] device_b,
  output logic                                 device_c_valid,
  input  logic                                 device_c_ready,
  output logic [CFields+DeviceSourceWidth-1:0] device_c,
  input  logic                                 device_d_valid,
  output logic                                 device_d_ready,
  input  logic [DFields+DeviceSourceWidth-1:0] device_d,
  output logic                                 device_e_valid,
  input  logic                                 device_e_ready,
  output logic [SinkWidth-1:0]                 device_e
);

  localparam int NumId = 2 ** DeviceSourceWidth;
  localparam int AFull = AFields + HostSourceWidth;
  localparam int DFull = DFields + DeviceSourceWidth;

  if (DeviceSourceWidth >= HostSourceWidth) begin : g_param_check
    $fatal(1, "tl_source_shrinker: DeviceSourceWidth must be below HostSourceWidth");
  end

  logic [NumId-1:0]           id_valid_q;
  logic [HostSourceWidth-1:0] id_source_q [NumId];
  logic                       a_busy_q;
  logic [DeviceSourceWidth-1:0] a_id_q;

  logic                         free_found;
  logic [DeviceSourceWidth-1:0] free_id;
  logic                         a_ok, a_fire, d_fire;
  logic                         req_first, req_last, gnt_last;
  logic [DeviceSourceWidth-1:0] d_id;

  // Lowest free ID wins; scanning downward lets the last hit be the lowest index.
  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = NumId - 1; i >= 0; i--) begin
      if (!id_valid_q[i]) begin
        free_found = 1'b1;
        free_id    = DeviceSourceWidth'(i);
      end
    end
  end

  assign a_ok           = a_busy_q | free_found;
  assign device_a_valid = host_a_valid & a_ok;
  assign host_a_ready   = device_a_ready & a_ok;
  assign device_a       = {host_a[AFull-1:HostSourceWidth], a_busy_q ? a_id_q : free_id};
  assign a_fire         = device_a_valid & device_a_ready;

  assign d_id           = device_d[DeviceSourceWidth-1:0];
  assign host_d_valid   = device_d_valid;
  assign device_d_ready = host_d_ready;
  assign host_d         = {device_d[DFull-1:DeviceSourceWidth], id_source_q[d_id]};
  assign d_fire         = device_d_valid & host_d_ready;

  tl_burst_tracker #(
    .DataWidth (DataWidth),
    .MaxSize   (MaxSize),
    .SizeWidth (SizeWidth)
  ) u_burst_tracker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .a_fire_i    (a_fire),
    .a_opcode_i  (host_a[AFull-1 -: 3]),
    .a_size_i    (host_a[AFull-7 -: SizeWidth]),
    .d_fire_i    (d_fire),
    .d_opcode_i  (device_d[DFull-1 -: 3]),
    .d_size_i    (device_d[DFull-6 -: SizeWidth]),
    .req_first_o (req_first),
    .req_last_o  (req_last),
    .gnt_last_o  (gnt_last)
  );

  // Allocation is written after the free so it wins; the two never target the same ID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_valid_q <= '0;
      a_busy_q   <= 1'b0;
      a_id_q     <= '0;
    end else begin
      if (d_fire && gnt_last) id_valid_q[d_id] <= 1'b0;
      if (a_fire && !a_busy_q) begin
        id_valid_q[free_id] <= 1'b1;
        if (req_first && !req_last) begin
          a_busy_q <= 1'b1;
          a_id_q   <= free_id;
        end
      end else if (a_fire && req_last) begin
        a_busy_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (a_fire && !a_busy_q) id_source_q[free_id] <= host_a[HostSourceWidth-1:0];
  end

  assign host_b_valid   = 1'b0;
  assign host_b         = 'x;
  assign host_c_ready   = 1'b1;
  assign host_e_ready   = 1'b1;
  assign device_b_ready = 1'b1;
  assign device_c_valid = 1'b0;
  assign device_c       = 'x;
  assign device_e_valid = 1'b0;
  assign device_e       = 'x;

  logic unused_inputs;
  assign unused_inputs = ^{host_b_ready, host_c_valid, host_c, host_e_valid, host_e,
                           device_b_valid, device_b, device_c_ready, device_e_ready};

endmodule

`default_nettype wire

// File: tb/tb_tl_source_shrinker.sv
// Directed bench for tl_source_shrinker with default parameters (64-bit data, 1-bit device source).
`default_nettype none

module tb_tl_source_shrinker;

  localparam logic [2:0] OP_PUTFULL = 3'd0;
  localparam logic [2:0] OP_GET     = 3'd4;
  localparam logic [2:0] OP_ACK     = 3'd0;
  localparam logic [2:0] OP_ACKDATA = 3'd1;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         host_a_valid, host_a_ready;
  logic [141:0] host_a;
  logic         host_b_valid, host_b_ready;
  logic [140:0] host_b;
  logic         host_c_valid, host_c_ready;
  logic [133:0] host_c;
  logic         host_d_valid, host_d_ready;
  logic [78:0]  host_d;
  logic         host_e_valid, host_e_ready;
  logic [0:0]   host_e;
  logic         device_a_valid, device_a_ready;
  logic [138:0] device_a;
  logic         device_b_valid, device_b_ready;
  logic [137:0] device_b;
  logic         device_c_valid, device_c_ready;
  logic [130:0] device_c;
  logic         device_d_valid, device_d_ready;
  logic [75:0]  device_d;
  logic         device_e_valid, device_e_ready;
  logic [0:0]   device_e;

  logic [137:0] a_fields;
  logic [74:0]  d_fields;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk_i = ~clk_i;

  tl_source_shrinker dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .host_a_valid   (host_a_valid),
    .host_a_ready   (host_a_ready),
    .host_a         (host_a),
    .host_b_valid   (host_b_valid),
    .host_b_ready   (host_b_ready),
    .host_b         (host_b),
    .host_c_valid   (host_c_valid),
    .host_c_ready   (host_c_ready),
    .host_c         (host_c),
    .host_d_valid   (host_d_valid),
    .host_d_ready   (host_d_ready),
    .host_d         (host_d),
    .host_e_valid   (host_e_valid),
    .host_e_ready   (host_e_ready),
    .host_e         (host_e),
    .device_a_valid (device_a_valid),
    .device_a_ready (device_a_ready),
    .device_a       (device_a),
    .device_b_valid (device_b_valid),
    .device_b_ready (device_b_ready),
    .device_b       (device_b),
    .device_c_valid (device_c_valid),
    .device_c_ready (device_c_ready),
    .device_c       (device_c),
    .device_d_valid (device_d_valid),
    .device_d_ready (device_d_ready),
    .device_d       (device_d),
    .device_e_valid (device_e_valid),
    .device_e_ready (device_e_ready),
    .device_e       (device_e)
  );

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [3:0] src, input logic [55:0] addr);
    a_fields     = {op, 3'd0, sz, addr, 8'hFF, {8'hA5, addr}, 1'b0};
    host_a       = {a_fields, src};
    host_a_valid = v;
  endtask

  task automatic drive_d(input logic v, input logic [2:0] op, input logic [2:0] sz,
                         input logic id);
    d_fields       = {op, 2'd0, sz, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_1234, 1'b0};
    device_d       = {d_fields, id};
    device_d_valid = v;
  endtask

  initial begin
    rst_ni         = 1'b0;
    host_b_ready   = 1'b1;
    host_c_valid   = 1'b0;
    host_c         = '0;
    host_e_valid   = 1'b0;
    host_e         = '0;
    device_b_valid = 1'b0;
    device_b       = '0;
    device_c_ready = 1'b1;
    device_e_ready = 1'b1;
    device_a_ready = 1'b1;
    host_d_ready   = 1'b1;
    drive_a(1'b0, OP_GET, 3'd3, 4'd0, 56'h0);
    drive_d(1'b0, OP_ACK, 3'd3, 1'b0);

    @(negedge clk_i);
    check("rst_dev_a_valid", device_a_valid, 1'b0);
    check("rst_host_a_ready", host_a_ready, 1'b1);
    check("rst_host_d_valid", host_d_valid, 1'b0);
    check("rst_host_b_valid", host_b_valid, 1'b0);
    check("rst_host_c_ready", host_c_ready, 1'b1);
    check("rst_host_e_ready", host_e_ready, 1'b1);
    check("rst_dev_b_ready", device_b_ready, 1'b1);
    check("rst_dev_c_valid", device_c_valid, 1'b0);
    check("rst_dev_e_valid", device_e_valid, 1'b0);
    tick();
    rst_ni = 1'b1;

    // Single Get, source 5, takes ID 0; response restores source 5
    drive_a(1'b1, OP_GET, 3'd3, 4'd5, 56'h1000);
    @(negedge clk_i);
    check("get5_valid", device_a_valid, 1'b1);
    check("get5_ready", host_a_ready, 1'b1);
    check("get5_dev_a", device_a, {a_fields, 1'b0});
    tick();
    drive_a(1'b0, OP_GET, 3'd3, 4'd0, 56'h0);
    drive_d(1'b1, OP_ACKDATA, 3'd3, 1'b0);
    @(negedge clk_i);
    check("d5_valid", host_d_valid, 1'b1);
    check("d5_host_d", host_d, {d_fields, 4'd5});
    check("d5_dev_d_ready", device_d_ready, 1'b1);
    tick();
    drive_d(1'b0, OP_ACK, 3'd3, 1'b0);

    // Gets 3 and 9 take IDs 0 and 1; Get 4 then stalls
    drive_a(1'b1, OP_GET, 3'd3, 4'd3, 56'h2000);
    @(negedge clk_i);
    check("get3_dev_a", device_a, {a_fields, 1'b0});
    tick();
    drive_a(1'b1, OP_GET, 3'd3, 4'd9, 56'h3000);
    @(negedge clk_i);
    check("get9_dev_a", device_a, {a_fields, 1'b1});
    check("get9_ready", host_a_ready, 1'b1);
    tick();
    drive_a(1'b1, OP_GET, 3'd3, 4'd4, 56'h4000);
    @(negedge clk_i);
    check("full_ready", host_a_ready, 1'b0);
    check("full_valid", device_a_valid, 1'b0);
    tick();
    // ID 0 freed this cycle: A must still stall until the next
    drive_d(1'b1, OP_ACKDATA, 3'd3, 1'b0);
    @(negedge clk_i);
    check("d3_host_d", host_d, {d_fields, 4'd3});
    check("same_cyc_ready", host_a_ready, 1'b0);
    check("same_cyc_valid", device_a_valid, 1'b0);
    tick();
    drive_d(1'b0, OP_ACK, 3'd3, 1'b0);
    @(negedge clk_i);
    check("get4_valid", device_a_valid, 1'b1);
    check("get4_dev_a", device_a, {a_fields, 1'b0});
    tick();

    // 8-beat AccessAckData for ID 1 (source 9); Get 2 waits for ID 1
    drive_a(1'b1, OP_GET, 3'd3, 4'd2, 56'h5000);
    for (int b = 0; b < 8; b++) begin
      drive_d(1'b1, OP_ACKDATA, 3'd6, 1'b1);
      @(negedge clk_i);
      check($sformatf("burst_d_src_b%0d", b), host_d, {d_fields, 4'd9});
      check($sformatf("burst_d_stall_b%0d", b), device_a_valid, 1'b0);
      tick();
    end
    drive_d(1'b0, OP_ACK, 3'd3, 1'b0);
    @(negedge clk_i);
    check("get2_valid", device_a_valid, 1'b1);
    check("get2_dev_a", device_a, {a_fields, 1'b1});
    tick();
    drive_a(1'b0, OP_GET, 3'd3, 4'd0, 56'h0);

    // D back-pressure passes through, then free IDs 0 (source 4) and 1 (source 2)
    host_d_ready = 1'b0;
    drive_d(1'b1, OP_ACK, 3'd3, 1'b0);
    @(negedge clk_i);
    check("d_bp_ready", device_d_ready, 1'b0);
    check("d_bp_valid", host_d_valid, 1'b1);
    tick();
    host_d_ready = 1'b1;
    @(negedge clk_i);
    check("d4_host_d", host_d, {d_fields, 4'd4});
    tick();
    drive_d(1'b1, OP_ACK, 3'd3, 1'b1);
    @(negedge clk_i);
    check("d2_host_d", host_d, {d_fields, 4'd2});
    tick();
    drive_d(1'b0, OP_ACK, 3'd3, 1'b0);

    // Get 11 takes ID 0; 8-beat PutFull source 7 takes ID 1 and fills the table
    drive_a(1'b1, OP_GET, 3'd3, 4'd11, 56'h6000);
    @(negedge clk_i);
    check("get11_dev_a", device_a, {a_fields, 1'b0});
    tick();
    for (int b = 0; b < 8; b++) begin
      drive_a(1'b1, OP_PUTFULL, 3'd6, 4'd7, 56'h7000);
      if (b == 3) begin
        device_a_ready = 1'b0;
        @(negedge clk_i);
        check("put_bp_ready", host_a_ready, 1'b0);
        check("put_bp_valid", device_a_valid, 1'b1);
        tick();
        device_a_ready = 1'b1;
      end
      @(negedge clk_i);
      check($sformatf("put_valid_b%0d", b), device_a_valid, 1'b1);
      check($sformatf("put_dev_a_b%0d", b), device_a, {a_fields, 1'b1});
      tick();
    end
    drive_a(1'b1, OP_GET, 3'd3, 4'd12, 56'h8000);
    @(negedge clk_i);
    check("after_put_ready", host_a_ready, 1'b0);
    tick();

    // Clear the table, start a Put on ID 0, then reset mid-burst
    rst_ni = 1'b0;
    drive_a(1'b0, OP_GET, 3'd3, 4'd0, 56'h0);
    tick();
    rst_ni = 1'b1;
    for (int b = 0; b < 3; b++) begin
      drive_a(1'b1, OP_PUTFULL, 3'd6, 4'd7, 56'h9000);
      @(negedge clk_i);
      check($sformatf("put2_dev_a_b%0d", b), device_a, {a_fields, 1'b0});
      tick();
    end
    rst_ni = 1'b0;
    drive_a(1'b0, OP_GET, 3'd3, 4'd0, 56'h0);
    @(negedge clk_i);
    check("midrst_valid", device_a_valid, 1'b0);
    check("midrst_ready", host_a_ready, 1'b1);
    tick();
    rst_ni = 1'b1;
    drive_a(1'b1, OP_GET, 3'd3, 4'd6, 56'hA000);
    @(negedge clk_i);
    check("post_rst_get6", device_a, {a_fields, 1'b0});
    tick();
    drive_a(1'b1, OP_GET, 3'd3, 4'd13, 56'hB000);
    @(negedge clk_i);
    check("post_rst_get13", device_a, {a_fields, 1'b1});
    tick();
    drive_a(1'b0, OP_GET, 3'd3, 4'd0, 56'h0);
    drive_d(1'b1, OP_ACKDATA, 3'd3, 1'b0);
    @(negedge clk_i);
    check("post_rst_d6", host_d, {d_fields, 4'd6});
    tick();
    drive_d(1'b0, OP_ACK, 3'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
